mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single tiny-AXI master port (one write channel, one read channel)
//  between the data cache (write-back + refill) and the instruction cache (refill).
//  Buffers one pending request per source, grants one memory transaction at a time,
//  and routes write-response / read-data / read-finish back to the owning cache.
//  Sits between lsu_stage / IF-stage cache control and the tiny AXI bus master.
// PARAMETERS
//  MAX_DC_RUN  4  consecutive DC grants allowed while an IC read waits (1..15)
//  IC_WAIT_WB  1  1: IC read is never granted while a DC write is pending/outstanding
// PORTS
//  clk               in   1    system clock
//  rst_n             in   1    async active-low reset
//  dcw_start_rq      in   1    DC write request pulse (1 cycle)
//  dcw_in_addr/mask  in   32/16 DC write address / byte mask
//  dcw_in_data       in   128  DC write line data
//  dcw_finish_wresp  out  1    DC write done pulse
//  dcr_start_rq      in   1    DC read request pulse
//  dcr_rin_addr      in   32   DC read address
//  dc_rdat_valid     out  1    DC read data valid (data on rdat_data)
//  dc_finish_mrd     out  1    DC read done pulse
//  icr_start_rq      in   1    IC read request pulse
//  icr_rin_addr      in   32   IC read address
//  ic_rdat_valid     out  1    IC read data valid (data on rdat_data)
//  ic_finish_mrd     out  1    IC read done pulse
//  rdat_data         out  128  read data, pass-through of rdat_m_data
//  m_w_start_rq      out  1    bus write start pulse
//  m_w_addr/mask     out  32/16 bus write address / mask
//  m_w_data          out  128  bus write data
//  m_finish_wresp    in   1    bus write response
//  m_r_start_rq      out  1    bus read start pulse
//  m_r_addr          out  32   bus read address
//  rdat_m_data       in   128  bus read data
//  rdat_m_valid      in   1    bus read data valid
//  finish_mrd        in   1    bus read finish
//  dc_wbback_state   out  1    DC write pending or outstanding (to IF)
//  arb_busy          out  1    state!=IDLE or any buffer full
//  arb_err           out  1    sticky: overflow or unexpected response
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, buffers WB/DR/IR empty, dc_run_cnt=0.
//  Capture: *_start_rq loads its buffer (addr/mask/data) on that edge, marks full.
//   Pulse while own buffer full or own type outstanding: ignored, arb_err<=1.
//   Pulse in the cycle its buffer is granted: accepted (load wins over clear).
//  FSM: IDLE, WAIT_W, WAIT_DR, WAIT_IR.
//   IDLE & any eligible buffer -> select winner, register m_*_start_rq=1 for
//   exactly 1 cycle with buffer fields, clear buffer, go WAIT_x. Min latency:
//   request pulse cycle N -> m start cycle N+2.
//   Priority WB > DR > IR; if IR full & dc_run_cnt==MAX_DC_RUN, IR wins.
//   IC_WAIT_WB=1: IR ineligible while WB full (WAIT_W already excludes issue).
//   dc_run_cnt: +1 per DC grant while IR full (saturating), 0 on IR grant or IR empty.
//   WAIT_W: m_finish_wresp -> dcw_finish_wresp same cycle (comb.), next IDLE.
//   WAIT_DR/IR: rdat_m_valid -> owner *_rdat_valid same cycle; finish_mrd ->
//   owner *_finish_mrd same cycle, next IDLE. valid+finish same cycle legal.
//   Finish in cycle F -> next m start at earliest F+2.
//  Responses not matching state (wresp outside WAIT_W, rdat/finish outside
//   WAIT_DR/IR) are dropped, arb_err<=1; state unchanged.
//  rdat_data = rdat_m_data always; valid qualifies ownership.
//  m_w_* / m_r_addr hold value from last grant until next grant.
//  dc_wbback_state = WB full | state==WAIT_W (comb.).
//  rst_n low mid-transaction: everything returns to reset values; bus assumed reset too.
//  arb_err cleared only by rst_n.
// TESTING
//  DC read @0x0000_1230 alone -> m_r_start_rq 2 cycles later, m_r_addr=0x1230;
//   rdat_m_valid+finish_mrd -> dc_rdat_valid, dc_finish_mrd same cycle, ic_* stay 0.
//  DC write 0x2000 and DC read 0x3000 same cycle -> write issued first; read
//   start exactly 2 cycles after m_finish_wresp; dc_wbback_state high until wresp.
//  IC read 0x100 pending with WB full, IC_WAIT_WB=1 -> IC held; granted after DC
//   write completes; ic_finish_mrd routed, dc_finish_mrd stays 0.
//  IC read waiting, 6 back-to-back DC reads, MAX_DC_RUN=4 -> grant order
//   DC,DC,DC,DC,IC,DC,DC.
//  Second dcr_start_rq while DC read outstanding -> ignored, arb_err=1, one m start.
//  finish_mrd in IDLE -> no outputs pulse, arb_err=1; rst_n low in WAIT_DR -> all 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Tiny-AXI master port arbiter shared by D-cache write-back/refill and I-cache refill.
// One buffered request per source; one bus transaction in flight at a time.
module mem_bus_arbiter #(
    parameter int unsigned MAX_DC_RUN = 4,
    parameter bit          IC_WAIT_WB = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dcw_start_rq,
    input  logic [31:0]  dcw_in_addr,
    input  logic [15:0]  dcw_in_mask,
    input  logic [127:0] dcw_in_data,
    output logic         dcw_finish_wresp,
    input  logic         dcr_start_rq,
    input  logic [31:0]  dcr_rin_addr,
    output logic         dc_rdat_valid,
    output logic         dc_finish_mrd,
    input  logic         icr_start_rq,
    input  logic [31:0]  icr_rin_addr,
    output logic         ic_rdat_valid,
    output logic         ic_finish_mrd,
    output logic [127:0] rdat_data,
    output logic         m_w_start_rq,
    output logic [31:0]  m_w_addr,
    output logic [15:0]  m_w_mask,
    output logic [127:0] m_w_data,
    input  logic         m_finish_wresp,
    output logic         m_r_start_rq,
    output logic [31:0]  m_r_addr,
    input  logic [127:0] rdat_m_data,
    input  logic         rdat_m_valid,
    input  logic         finish_mrd,
    output logic         dc_wbback_state,
    output logic         arb_busy,
    output logic         arb_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_W,
        WAIT_DR,
        WAIT_IR
    } state_e;

    localparam logic [3:0] MaxRun = 4'(MAX_DC_RUN);

    state_e        state_q, state_d;
    logic          wb_full_q, wb_full_d;
    logic [31:0]   wb_addr_q;
    logic [15:0]   wb_mask_q;
    logic [127:0]  wb_data_q;
    logic          dr_full_q, dr_full_d;
    logic [31:0]   dr_addr_q;
    logic          ir_full_q, ir_full_d;
    logic [31:0]   ir_addr_q;
    logic [3:0]    run_cnt_q, run_cnt_d;
    logic          mw_start_q;
    logic [31:0]   mw_addr_q;
    logic [15:0]   mw_mask_q;
    logic [127:0]  mw_data_q;
    logic          mr_start_q;
    logic [31:0]   mr_addr_q;
    logic          err_q, err_d;

    logic idle;
    logic ir_elig;
    logic grant_wb, grant_dr, grant_ir;
    logic wb_acc, dr_acc, ir_acc;
    logic rq_err, rsp_err;

    assign idle    = (state_q == IDLE);
    assign ir_elig = ir_full_q && !(IC_WAIT_WB && wb_full_q);

    // IR wins either when nothing else is queued or when DC has used up its run
    assign grant_ir = idle && ir_elig &&
                      ((run_cnt_q == MaxRun) || (!wb_full_q && !dr_full_q));
    assign grant_wb = idle && wb_full_q && !grant_ir;
    assign grant_dr = idle && dr_full_q && !wb_full_q && !grant_ir;

    // A request landing on the cycle its buffer is granted refills the buffer
    assign wb_acc = dcw_start_rq && (!wb_full_q || grant_wb) && (state_q != WAIT_W);
    assign dr_acc = dcr_start_rq && (!dr_full_q || grant_dr) && (state_q != WAIT_DR);
    assign ir_acc = icr_start_rq && (!ir_full_q || grant_ir) && (state_q != WAIT_IR);

    assign rq_err = (dcw_start_rq && !wb_acc) ||
                    (dcr_start_rq && !dr_acc) ||
                    (icr_start_rq && !ir_acc);

    assign rsp_err = (m_finish_wresp && (state_q != WAIT_W)) ||
                     ((rdat_m_valid || finish_mrd) &&
                      (state_q != WAIT_DR) && (state_q != WAIT_IR));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_wb)      state_d = WAIT_W;
                else if (grant_dr) state_d = WAIT_DR;
                else if (grant_ir) state_d = WAIT_IR;
            end
            WAIT_W:  if (m_finish_wresp) state_d = IDLE;
            WAIT_DR: if (finish_mrd)     state_d = IDLE;
            WAIT_IR: if (finish_mrd)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_full_d = wb_full_q;
        dr_full_d = dr_full_q;
        ir_full_d = ir_full_q;
        if (grant_wb) wb_full_d = 1'b0;
        if (grant_dr) dr_full_d = 1'b0;
        if (grant_ir) ir_full_d = 1'b0;
        if (wb_acc)   wb_full_d = 1'b1;
        if (dr_acc)   dr_full_d = 1'b1;
        if (ir_acc)   ir_full_d = 1'b1;
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!ir_full_q || grant_ir) begin
            run_cnt_d = 4'd0;
        end else if ((grant_wb || grant_dr) && (run_cnt_q != 4'hF)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    assign err_d = err_q || rq_err || rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wb_full_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_mask_q  <= '0;
            wb_data_q  <= '0;
            dr_full_q  <= 1'b0;
            dr_addr_q  <= '0;
            ir_full_q  <= 1'b0;
            ir_addr_q  <= '0;
            run_cnt_q  <= '0;
            mw_start_q <= 1'b0;
            mw_addr_q  <= '0;
            mw_mask_q  <= '0;
            mw_data_q  <= '0;
            mr_start_q <= 1'b0;
            mr_addr_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_full_q  <= wb_full_d;
            dr_full_q  <= dr_full_d;
            ir_full_q  <= ir_full_d;
            run_cnt_q  <= run_cnt_d;
            err_q      <= err_d;
            mw_start_q <= grant_wb;
            mr_start_q <= grant_dr || grant_ir;
            if (wb_acc) begin
                wb_addr_q <= dcw_in_addr;
                wb_mask_q <= dcw_in_mask;
                wb_data_q <= dcw_in_data;
            end
            if (dr_acc) dr_addr_q <= dcr_rin_addr;
            if (ir_acc) ir_addr_q <= icr_rin_addr;
            if (grant_wb) begin
                mw_addr_q <= wb_addr_q;
                mw_mask_q <= wb_mask_q;
                mw_data_q <= wb_data_q;
            end
            if (grant_dr)      mr_addr_q <= dr_addr_q;
            else if (grant_ir) mr_addr_q <= ir_addr_q;
        end
    end

    assign dcw_finish_wresp = (state_q == WAIT_W) && m_finish_wresp;
    assign dc_rdat_valid    = (state_q == WAIT_DR) && rdat_m_valid;
    assign dc_finish_mrd    = (state_q == WAIT_DR) && finish_mrd;
    assign ic_rdat_valid    = (state_q == WAIT_IR) && rdat_m_valid;
    assign ic_finish_mrd    = (state_q == WAIT_IR) && finish_mrd;
    assign rdat_data        = rdat_m_data;

    assign m_w_start_rq = mw_start_q;
    assign m_w_addr     = mw_addr_q;
    assign m_w_mask     = mw_mask_q;
    assign m_w_data     = mw_data_q;
    assign m_r_start_rq = mr_start_q;
    assign m_r_addr     = mr_addr_q;

    assign dc_wbback_state = wb_full_q || (state_q == WAIT_W);
    assign arb_busy        = !idle || wb_full_q || dr_full_q || ir_full_q;
    assign arb_err         = err_q;

endmodule
